// File: rtl/slice_add_seq.sv
// Multi-cycle W-bit adder: steps an N-bit ripple-carry slice across the
// latched operands LSB-first, one slice per clock, with valid/ready on both sides.
module slice_add_seq #(
  parameter int N = 2,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         co,
  output logic         ovf,
  output logic         busy
);

  localparam int S  = W / N;
  localparam int IW = (S > 1) ? $clog2(S) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, next_state;
  logic [W-1:0]   a_reg, b_reg;
  logic           carry;
  logic [IW-1:0]  idx;
  logic [N-1:0]   a_sl, b_sl, s_sl;
  logic           slice_co, msb_cin, last;

  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int k = 0; k < S; k++) begin
      if (idx == IW'(k)) begin
        a_sl = a_reg[k*N +: N];
        b_sl = b_reg[k*N +: N];
      end
    end
    last = (idx == IW'(S - 1));
  end

  // msb_cin is the carry into the slice's top bit; on the last slice that is
  // the carry into bit W-1, which the overflow rule needs.
  always_comb begin : ripple
    logic cr;
    cr      = carry;
    s_sl    = '0;
    msb_cin = 1'b0;
    for (int i = 0; i < N; i++) begin
      msb_cin = cr;
      s_sl[i] = a_sl[i] ^ b_sl[i] ^ cr;
      cr      = (a_sl[i] & b_sl[i]) | (a_sl[i] & cr) | (b_sl[i] & cr);
    end
    slice_co = cr;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) next_state = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      co    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            carry <= ci;
            idx   <= '0;
          end
        end
        RUN: begin
          for (int k = 0; k < S; k++) begin
            if (idx == IW'(k)) sum[k*N +: N] <= s_sl;
          end
          carry <= slice_co;
          idx   <= idx + IW'(1);
          if (last) begin
            co  <= slice_co;
            ovf <= msb_cin ^ slice_co;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
